// File: rtl/calc_input_entry.sv
// Purpose : calculator operand-entry controller; debounces buttons, builds op_a/op_b/op_sel,
//           issues them to the ALU over valid/ready, captures the result for the display.
// Latency : button press acts DEBOUNCE_CYCLES+4 edges after the raw level is first sampled.
// Backpressure: req_valid and operands are held in ISSUE until alu_ready; buttons except mode are ignored there.
// Ports   : clk/rst_n; btn_up/down/enter/clear/mode raw buttons; alu_ready, alu_result, result_valid
//           from the ALU; op_a, op_b, op_sel, req_valid to the ALU; display_data, display_mode, state.
module calc_input_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       alu_ready,
  input  logic [5:0] alu_result,
  input  logic       result_valid,
  output logic [5:0] op_a,
  output logic [5:0] op_b,
  output logic [1:0] op_sel,
  output logic       req_valid,
  output logic [5:0] display_data,
  output logic       display_mode,
  output logic [2:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTER_A     = 3'd0,
    S_ENTER_B     = 3'd1,
    S_ENTER_OP    = 3'd2,
    S_ISSUE       = 3'd3,
    S_WAIT_RESULT = 3'd4,
    S_SHOW        = 3'd5
  } state_e;

  // Button bit order: 0 up, 1 down, 2 enter, 3 clear, 4 mode.
  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]    deb_q, deb_d, deb_dly_q, deb_dly_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];

  assign btn_raw = {btn_mode, btn_clear, btn_enter, btn_down, btn_up};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The edge that would make the count reach DEBOUNCE_CYCLES flips the level instead.
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // Rising edge of the debounced level, seen one cycle after it flips.
    pulse_d = deb_q & ~deb_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic ev_up, ev_dn, ev_ent, ev_clr, ev_mode;
  // Simultaneous up and down cancel each other.
  assign ev_up   = pulse_q[0] & ~pulse_q[1];
  assign ev_dn   = pulse_q[1] & ~pulse_q[0];
  assign ev_ent  = pulse_q[2];
  assign ev_clr  = pulse_q[3];
  assign ev_mode = pulse_q[4];

  state_e     state_q, state_d;
  logic [5:0] entry_q, entry_d, op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [1:0] op_sel_q, op_sel_d;
  logic       req_valid_q, req_valid_d, disp_mode_q, disp_mode_d;

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    result_d    = result_q;
    req_valid_d = req_valid_q;
    disp_mode_d = ev_mode ? ~disp_mode_q : disp_mode_q;

    if (ev_clr && state_q != S_ISSUE) begin
      entry_d = '0;
      state_d = S_ENTER_A;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (ev_ent) begin
            op_a_d  = entry_q;
            entry_d = '0;
            state_d = S_ENTER_B;
          end else if (ev_up) entry_d = entry_q + 6'd1;
          else if (ev_dn)     entry_d = entry_q - 6'd1;
        end
        S_ENTER_B: begin
          if (ev_ent) begin
            op_b_d  = entry_q;
            state_d = S_ENTER_OP;
          end else if (ev_up) entry_d = entry_q + 6'd1;
          else if (ev_dn)     entry_d = entry_q - 6'd1;
        end
        S_ENTER_OP: begin
          if (ev_ent) begin
            req_valid_d = 1'b1;
            state_d     = S_ISSUE;
          end else if (ev_up) op_sel_d = op_sel_q + 2'd1;
          else if (ev_dn)     op_sel_d = op_sel_q - 2'd1;
        end
        S_ISSUE: begin
          if (req_valid_q && alu_ready) begin
            req_valid_d = 1'b0;
            state_d     = S_WAIT_RESULT;
          end
        end
        S_WAIT_RESULT: begin
          if (result_valid) begin
            result_d = alu_result;
            state_d  = S_SHOW;
          end
        end
        S_SHOW: begin
          if (ev_ent) begin
            entry_d = result_q;
            state_d = S_ENTER_A;
          end
        end
        default: state_d = S_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ENTER_A;
      entry_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      result_q    <= '0;
      req_valid_q <= 1'b0;
      disp_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      result_q    <= result_d;
      req_valid_q <= req_valid_d;
      disp_mode_q <= disp_mode_d;
    end
  end

  always_comb begin
    case (state_q)
      S_ENTER_A, S_ENTER_B:   display_data = entry_q;
      S_ENTER_OP:             display_data = {4'd0, op_sel_q};
      S_ISSUE, S_WAIT_RESULT: display_data = op_b_q;
      S_SHOW:                 display_data = result_q;
      default:                display_data = entry_q;
    endcase
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_sel       = op_sel_q;
  assign req_valid    = req_valid_q;
  assign display_mode = disp_mode_q;
  assign state        = state_q;

endmodule

// File: tb/tb_calc_input_entry.sv
// Directed bench for calc_input_entry with DEBOUNCE_CYCLES=4; expected values are queued
// as stimulus is driven and popped when the corresponding output is sampled.
module tb_calc_input_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;  // 0 up, 1 down, 2 enter, 3 clear, 4 mode
  logic       alu_ready, result_valid;
  logic [5:0] alu_result;
  logic [5:0] op_a, op_b, display_data;
  logic [1:0] op_sel;
  logic       req_valid, display_mode;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  calc_input_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_enter(btn[2]), .btn_clear(btn[3]), .btn_mode(btn[4]),
    .alu_ready(alu_ready), .alu_result(alu_result), .result_valid(result_valid),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .req_valid(req_valid),
    .display_data(display_data), .display_mode(display_mode), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] all_out();
    return {7'd0, state, req_valid, display_mode, op_sel, op_a, op_b, display_data};
  endfunction

  task automatic expv(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    repeat (10) tick();
    btn = '0;
    repeat (10) tick();
  endtask

  initial begin
    rst_n = 1'b1; btn = '0; alu_ready = 1'b0; result_valid = 1'b0; alu_result = '0;

    // 1. asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1 expv(32'd0); chk("reset_async", all_out());
    repeat (3) tick();
    expv(32'd0); chk("reset_hold", all_out());
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 2. debounce: short glitch ignored, long hold gives exactly one step
    btn[0] = 1'b1; repeat (2) tick(); btn[0] = 1'b0;
    repeat (10) tick();
    expv(32'd0); chk("glitch_ignored", {26'd0, display_data});
    btn[0] = 1'b1;
    repeat (7) tick();
    expv(32'd0); chk("before_action_edge8", {26'd0, display_data});
    tick();
    expv(32'd1); chk("after_edge8", {26'd0, display_data});
    repeat (92) tick();
    expv(32'd1); chk("hold_100", {26'd0, display_data});
    btn[0] = 1'b0; repeat (10) tick();

    // 3. wrap-around of entry and op_sel
    for (int i = 0; i < 30; i++) press(5'b00001);
    expv(32'd31); chk("entry_31", {26'd0, display_data});
    press(5'b00001);
    expv(32'h20); chk("wrap_up_to_m32", {26'd0, display_data});
    press(5'b00010);
    expv(32'd31); chk("wrap_down_to_31", {26'd0, display_data});
    press(5'b00100);
    expv({29'd0, 3'd1}); chk("to_enter_b", {29'd0, state});
    press(5'b00100);
    press(5'b00010);
    expv(32'd3); chk("opsel_0_minus_1", {26'd0, display_data});
    press(5'b00001);
    expv(32'd0); chk("opsel_3_plus_1", {26'd0, display_data});
    press(5'b01000);
    expv({20'd0, 6'd31, 6'd0}); chk("clear_keeps_op_a", {20'd0, op_a, display_data});
    expv(32'd0); chk("clear_state", {29'd0, state});

    // 4. full transaction: A=5, B=-3, op_sel=1
    for (int i = 0; i < 5; i++) press(5'b00001);
    press(5'b00100);
    for (int i = 0; i < 3; i++) press(5'b00010);
    expv(32'h3D); chk("entry_m3", {26'd0, display_data});
    press(5'b00100);
    press(5'b00001);
    expv({30'd0, 2'd1}); chk("op_sel_1", {30'd0, op_sel});
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) expv({17'd0, 1'b1, 6'd5, 6'h3D, 2'd1});
    btn[2] = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      chk("req_hold", {17'd0, req_valid, op_a, op_b, op_sel});
      if (i == 3) alu_ready = 1'b1;
      if (i < 3) tick();
    end
    tick();
    alu_ready = 1'b0;
    expv({28'd0, 3'd4, 1'b0}); chk("after_transfer", {28'd0, state, req_valid});
    btn[2] = 1'b0; repeat (10) tick();
    alu_result = 6'd2; result_valid = 1'b1; tick(); result_valid = 1'b0;
    expv({23'd0, 3'd5, 6'd2}); chk("show_result", {23'd0, state, display_data});
    press(5'b00100);
    expv({23'd0, 3'd0, 6'd2}); chk("chain_entry", {23'd0, state, display_data});

    // 5. priority and simultaneity
    press(5'b00100);
    press(5'b01100);
    expv({17'd0, 3'd0, 6'd0, 6'h3D}); chk("clear_beats_enter", {17'd0, state, display_data, op_b});
    press(5'b00001);
    press(5'b00011);
    expv(32'd1); chk("up_down_cancel", {26'd0, display_data});
    press(5'b00100);
    press(5'b00100);
    press(5'b00100);
    expv({28'd0, 3'd3, 1'b1}); chk("in_issue", {28'd0, state, req_valid});
    press(5'b01000);
    expv({28'd0, 3'd3, 1'b1}); chk("clear_ignored_issue", {28'd0, state, req_valid});
    press(5'b10000);
    expv({27'd0, 3'd3, 1'b1, 1'b1}); chk("mode_in_issue", {27'd0, state, req_valid, display_mode});
    alu_ready = 1'b1; tick(); alu_ready = 1'b0;
    expv({28'd0, 3'd4, 1'b0}); chk("transfer2", {28'd0, state, req_valid});

    // 6. reset in WAIT_RESULT, then a stray result strobe
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expv(32'd0); chk("reset_mid_op", all_out());
    @(negedge clk) rst_n = 1'b1;
    tick();
    alu_result = 6'd7; result_valid = 1'b1; tick(); result_valid = 1'b0;
    tick();
    expv(32'd0); chk("stray_result_ignored", all_out());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
